inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 138 +++++++++++++
 tb/tb_inst_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding imem requests, registered
// decode output with a one-entry skid buffer and redirect handling.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        xfer;
  logic [31:0] pc_inc;

  assign xfer   = id_valid_q & ~stall;
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC & ALIGN;
      addr_q      <= '0;
      id_valid_q  <= 1'b0;
      id_inst_q   <= '0;
      id_pc_q     <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = imem_addr;
    id_valid_d  = id_valid_q & ~xfer;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if (redirect_valid) begin
      id_valid_d = 1'b0;
      pc_d       = redirect_pc & ALIGN;
      // An accepted or still-pending request must have its response dropped
      unique case (state_q)
        S_REQ:   state_d = imem_req_ready ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            pc_d = pc_inc;
            if (!id_valid_q || xfer) begin
              id_valid_d = 1'b1;
              id_inst_d  = imem_rsp_data;
              id_pc_d    = pc_q;
              state_d    = S_REQ;
            end else begin
              skid_inst_d = imem_rsp_data;
              skid_pc_d   = pc_q;
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (xfer) begin
            id_valid_d = 1'b1;
            id_inst_d  = skid_inst_q;
            id_pc_d    = skid_pc_q;
            state_d    = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_addr      = imem_req_valid ? pc_q : addr_q;
    id_valid       = id_valid_q;
    id_inst        = id_inst_q;
    id_pc          = id_pc_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming, stall/skid, redirects,
// backpressure, reset abandonment and pc wrap.
module tb_inst_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst, id_pc;

  logic        r2_valid;
  logic [31:0] r2_addr;
  logic        rsp2_valid = 1'b0;
  logic [31:0] rsp2_data = '0;
  logic        id2_valid;
  logic [31:0] id2_inst, id2_pc;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] zero32 = '0;

  int checks = 0;
  int errors = 0;
  bit auto_mem;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready),
    .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(r2_valid), .imem_req_ready(one),
    .imem_addr(r2_addr),
    .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
    .stall(zero),
    .redirect_valid(zero), .redirect_pc(zero32),
    .id_valid(id2_valid), .id_inst(id2_inst), .id_pc(id2_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; 1-cycle memory answers whatever was accepted this cycle
  task automatic cyc();
    logic        acc, acc2;
    logic [31:0] a, a2;
    acc  = req_valid & req_ready;
    a    = addr;
    acc2 = r2_valid;
    a2   = r2_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      rsp_valid = acc;
      rsp_data  = a ^ K;
    end
    rsp2_valid = acc2;
    rsp2_data  = a2 ^ K;
  endtask

  initial begin
    req_ready      = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    auto_mem       = 1'b1;

    #12;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_addr", addr, 32'd0);

    cyc();
    rst_n = 1'b1;
    chk("idle_no_req", 32'(req_valid), 32'd0);
    cyc();
    chk("c1_req_valid", 32'(req_valid), 32'd1);
    chk("c1_addr", addr, 32'h0);
    cyc();
    chk("c2_id_valid", 32'(id_valid), 32'd0);
    chk("c2_wait_no_req", 32'(req_valid), 32'd0);
    cyc();
    chk("c3_id_valid", 32'(id_valid), 32'd1);
    chk("c3_id_pc", id_pc, 32'h0);
    chk("c3_id_inst", id_inst, 32'hA5A5_0000);
    chk("c3_addr", addr, 32'h4);
    chk("wrap_id2_pc0", id2_pc, 32'hFFFF_FFFC);
    chk("wrap_id2_inst0", id2_inst, 32'h5A5A_FFFC);
    cyc();
    chk("c4_id_valid", 32'(id_valid), 32'd0);
    cyc();
    chk("c5_id_pc", id_pc, 32'h4);
    chk("c5_id_inst", id_inst, 32'hA5A5_0004);
    chk("wrap_id2_pc1", id2_pc, 32'h0);
    chk("wrap_id2_valid", 32'(id2_valid), 32'd1);
    cyc();
    cyc();
    chk("c7_id_pc", id_pc, 32'h8);
    chk("c7_id_inst", id_inst, 32'hA5A5_0008);
    chk("c7_addr", addr, 32'hC);

    stall = 1'b1;
    cyc();
    chk("c8_id_pc", id_pc, 32'h8);
    cyc();
    chk("hold_no_req", 32'(req_valid), 32'd0);
    chk("hold_id_valid", 32'(id_valid), 32'd1);
    chk("hold_id_inst", id_inst, 32'hA5A5_0008);
    cyc();
    cyc();
    chk("hold2_no_req", 32'(req_valid), 32'd0);
    chk("hold2_id_pc", id_pc, 32'h8);
    cyc();
    stall = 1'b0;
    cyc();
    chk("skid_id_valid", 32'(id_valid), 32'd1);
    chk("skid_id_pc", id_pc, 32'hC);
    chk("skid_id_inst", id_inst, 32'hA5A5_000C);
    chk("skid_addr", addr, 32'h10);
    cyc();
    chk("c14_id_valid", 32'(id_valid), 32'd0);
    cyc();
    chk("c15_id_pc", id_pc, 32'h10);
    chk("c15_id_inst", id_inst, 32'hA5A5_0010);

    stall = 1'b1;
    auto_mem = 1'b0;
    cyc();
    chk("c16_id_valid", 32'(id_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    cyc();
    chk("redir_id_valid", 32'(id_valid), 32'd0);
    chk("drop_no_req", 32'(req_valid), 32'd0);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    rsp_valid      = 1'b1;
    rsp_data       = 32'hDEAD_BEEF;
    cyc();
    chk("drop_id_valid", 32'(id_valid), 32'd0);
    chk("redir_req_valid", 32'(req_valid), 32'd1);
    chk("redir_addr", addr, 32'h0000_1000);
    rsp_valid = 1'b0;
    auto_mem  = 1'b1;
    cyc();
    cyc();
    chk("redir_id_pc", id_pc, 32'h0000_1000);
    chk("redir_id_inst", id_inst, 32'hA5A5_1000);

    stall = 1'b1;
    cyc();
    chk("c21_rsp_valid", 32'(rsp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    cyc();
    chk("coinc_id_valid", 32'(id_valid), 32'd0);
    chk("coinc_addr", addr, 32'h0000_2000);
    chk("coinc_req_valid", 32'(req_valid), 32'd1);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    cyc();
    chk("coinc_no_out", 32'(id_valid), 32'd0);
    cyc();
    chk("coinc_id_pc", id_pc, 32'h0000_2000);
    chk("coinc_id_inst", id_inst, 32'hA5A5_2000);

    req_ready = 1'b0;
    cyc();
    chk("bp1_valid", 32'(req_valid), 32'd1);
    chk("bp1_addr", addr, 32'h0000_2004);
    cyc();
    chk("bp2_valid", 32'(req_valid), 32'd1);
    chk("bp2_addr", addr, 32'h0000_2004);
    cyc();
    chk("bp3_valid", 32'(req_valid), 32'd1);
    chk("bp3_addr", addr, 32'h0000_2004);
    req_ready = 1'b1;
    cyc();
    cyc();
    chk("bp_id_pc", id_pc, 32'h0000_2004);
    chk("bp_id_inst", id_inst, 32'hA5A5_2004);
    chk("bp_next_addr", addr, 32'h0000_2008);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_id_valid", 32'(id_valid), 32'd0);
    chk("arst_req_valid", 32'(req_valid), 32'd0);
    chk("arst_addr", addr, 32'd0);
    chk("arst_id_pc", id_pc, 32'd0);
    auto_mem  = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = 32'h0BAD_0BAD;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_rsp_ignored", 32'(id_valid), 32'd0);
    chk("rerun_addr", addr, 32'd0);
    rsp_valid = 1'b0;
    auto_mem  = 1'b1;
    cyc();
    cyc();
    chk("rerun_id_valid", 32'(id_valid), 32'd1);
    chk("rerun_id_pc", id_pc, 32'd0);
    chk("rerun_id_inst", id_inst, 32'hA5A5_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
